// File: rtl/perf_memsys_ctr_bank.sv
// ---------------------------------------------------------------------------
// perf_memsys_ctr_bank
//
// Purpose:
//   A bank of generic memory-system performance counters. Each counter adds
//   a small increment every cycle. It either wraps or saturates, and all
//   counters share one synchronous clear. A snapshot engine copies every live
//   counter into shadow registers in a single cycle. It then streams the
//   frozen values out over a valid/ready channel, one counter per beat.
//
// Parameters:
//   NUM_CTRS   number of counters (1..64)
//   CTR_WIDTH  counter width (8..64), defaults to `PERF_CTR_BITS (44)
//   INC_WIDTH  per-cycle increment width (1..8)
//   SATURATE   0 = wrap modulo 2^CTR_WIDTH, 1 = saturate at all-ones
//
// Optional feature:
//   PERF_CTR_OVF_EN  when defined, each counter gets a sticky overflow flag.
//                    When undefined, ovf is tied to 0 and no flag registers
//                    are built.
//
// Ports:
//   clk         clock
//   reset_n     asynchronous active-low reset
//   enable      counting enable
//   clear       synchronous clear of all live counters (beats increment)
//   evt_inc     per-counter increments, slice i = [i*INC_WIDTH +: INC_WIDTH]
//   ctr_value   live counter values, slice i = [i*CTR_WIDTH +: CTR_WIDTH]
//   snap_valid  snapshot request
//   snap_ready  high while idle (a snapshot can be taken)
//   out_valid   streamed word valid
//   out_ready   consumer ready
//   out_idx     counter index of out_data
//   out_data    frozen counter value
//   out_last    marks the beat carrying index NUM_CTRS-1
//   ovf         sticky overflow flags
// ---------------------------------------------------------------------------
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

module perf_memsys_ctr_bank #(
    parameter int NUM_CTRS  = 14,
    parameter int CTR_WIDTH = `PERF_CTR_BITS,
    parameter int INC_WIDTH = 4,
    parameter int SATURATE  = 0,
    localparam int IDX_W    = (NUM_CTRS > 1) ? $clog2(NUM_CTRS) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          clear,
    input  logic [NUM_CTRS*INC_WIDTH-1:0] evt_inc,
    output logic [NUM_CTRS*CTR_WIDTH-1:0] ctr_value,
    input  logic                          snap_valid,
    output logic                          snap_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IDX_W-1:0]              out_idx,
    output logic [CTR_WIDTH-1:0]          out_data,
    output logic                          out_last,
    output logic [NUM_CTRS-1:0]           ovf
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_next;
    logic                 w_snap_take;
    logic                 w_at_last;

    logic [CTR_WIDTH-1:0] r_ctr    [NUM_CTRS];
    logic [CTR_WIDTH-1:0] r_shadow [NUM_CTRS];
    logic [CTR_WIDTH:0]   w_sum    [NUM_CTRS];

    // Sum with one extra bit so that the carry-out is visible.
    function automatic logic [CTR_WIDTH:0] f_add(input logic [CTR_WIDTH-1:0] a,
                                                 input logic [INC_WIDTH-1:0] b);
        return {1'b0, a} + (CTR_WIDTH+1)'(b);
    endfunction

    // Wrap drops the carry. Saturate clamps to all-ones on carry. A saturated
    // counter only changes again after a clear, because any non-zero
    // increment carries again.
    function automatic logic [CTR_WIDTH-1:0] f_limit(input logic [CTR_WIDTH:0] sum);
        if ((SATURATE != 0) && sum[CTR_WIDTH])
            return '1;
        else
            return sum[CTR_WIDTH-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_CTRS; i++)
            w_sum[i] = f_add(r_ctr[i], evt_inc[i*INC_WIDTH +: INC_WIDTH]);
    end

    // Live counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CTRS; i++) r_ctr[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_CTRS; i++) r_ctr[i] <= '0;
        end else if (enable) begin
            for (int i = 0; i < NUM_CTRS; i++) r_ctr[i] <= f_limit(w_sum[i]);
        end
    end

    always_comb begin
        ctr_value = '0;
        for (int i = 0; i < NUM_CTRS; i++)
            ctr_value[i*CTR_WIDTH +: CTR_WIDTH] = r_ctr[i];
    end

    // Shadow copy takes the pre-increment value of the handshake cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CTRS; i++) r_shadow[i] <= '0;
        end else if (w_snap_take) begin
            for (int i = 0; i < NUM_CTRS; i++) r_shadow[i] <= r_ctr[i];
        end
    end

    // Snapshot stream FSM
    assign w_at_last = (r_idx == IDX_W'(NUM_CTRS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_snap_take  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (snap_valid) begin
                    w_snap_take  = 1'b1;
                    w_idx_next   = '0;
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (out_ready) begin
                    if (w_at_last) begin
                        w_idx_next   = '0;
                        w_state_next = S_IDLE;
                    end else begin
                        w_idx_next   = r_idx + IDX_W'(1);
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // All stream outputs come from registers only (state, index, shadow).
    assign snap_ready = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_STREAM);
    assign out_idx    = r_idx;
    assign out_data   = r_shadow[r_idx];
    assign out_last   = (r_state == S_STREAM) && w_at_last;

`ifdef PERF_CTR_OVF_EN
    logic [NUM_CTRS-1:0] r_ovf;
    logic [NUM_CTRS-1:0] w_ovf_evt;

    always_comb begin
        w_ovf_evt = '0;
        for (int i = 0; i < NUM_CTRS; i++)
            w_ovf_evt[i] = w_sum[i][CTR_WIDTH];
    end

    // Clear wins over a same-cycle overflow, so the flag ends up 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_ovf <= '0;
        else if (clear)
            r_ovf <= '0;
        else if (enable)
            r_ovf <= r_ovf | w_ovf_evt;
    end

    assign ovf = r_ovf;
`else
    assign ovf = '0;
`endif

endmodule

// File: tb/tb_perf_memsys_ctr_bank.sv
module tb_perf_memsys_ctr_bank;
    localparam int N    = 14;
    localparam int CW   = 8;
    localparam int IW   = 4;
    localparam int IDXW = 4;
    localparam int MAXV = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic clear = 1'b0;
    logic snap_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [N*IW-1:0] evt_inc = '0;

    logic [N*CW-1:0] ctr_w;
    logic            snap_ready;
    logic            out_valid;
    logic [IDXW-1:0] out_idx;
    logic [CW-1:0]   out_data;
    logic            out_last;
    logic [N-1:0]    ovf_w;

    logic [N*CW-1:0] ctr_s;
    logic            s_snap_ready;
    logic            s_out_valid;
    logic [IDXW-1:0] s_out_idx;
    logic [CW-1:0]   s_out_data;
    logic            s_out_last;
    logic [N-1:0]    ovf_s;

    perf_memsys_ctr_bank #(.NUM_CTRS(N), .CTR_WIDTH(CW), .INC_WIDTH(IW), .SATURATE(0)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .evt_inc(evt_inc), .ctr_value(ctr_w), .snap_valid(snap_valid),
        .snap_ready(snap_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_data(out_data), .out_last(out_last), .ovf(ovf_w)
    );

    perf_memsys_ctr_bank #(.NUM_CTRS(N), .CTR_WIDTH(CW), .INC_WIDTH(IW), .SATURATE(1)) dut_sat (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .evt_inc(evt_inc), .ctr_value(ctr_s), .snap_valid(1'b0),
        .snap_ready(s_snap_ready), .out_valid(s_out_valid), .out_ready(1'b1),
        .out_idx(s_out_idx), .out_data(s_out_data), .out_last(s_out_last), .ovf(ovf_s)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integer counters plus a busy/remaining view of the stream
    int  m_w [N];
    int  m_s [N];
    bit  m_ovf_w [N];
    bit  m_ovf_s [N];
    bit  m_busy = 1'b0;
    int  m_rem  = 0;

    typedef struct {
        int idx;
        int data;
        bit last;
    } beat_t;
    beat_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_ovf(input bit f);
`ifdef PERF_CTR_OVF_EN
        return f;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_w[i] = 0; m_s[i] = 0; m_ovf_w[i] = 1'b0; m_ovf_s[i] = 1'b0;
        end
        m_busy = 1'b0;
        m_rem  = 0;
        sb.delete();
    endtask

    task automatic model_edge();
        int inc, sw, ss;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (!m_busy && snap_valid) begin
            for (int i = 0; i < N; i++) sb.push_back('{i, m_w[i], (i == N-1)});
            m_busy = 1'b1;
            m_rem  = N;
        end else if (m_busy && out_ready) begin
            m_rem--;
            if (m_rem == 0) m_busy = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            inc = int'(evt_inc[i*IW +: IW]);
            if (clear) begin
                m_w[i] = 0; m_s[i] = 0; m_ovf_w[i] = 1'b0; m_ovf_s[i] = 1'b0;
            end else if (enable) begin
                sw = m_w[i] + inc;
                if (sw > MAXV) m_ovf_w[i] = 1'b1;
                m_w[i] = sw % (MAXV + 1);
                ss = m_s[i] + inc;
                if (ss > MAXV) begin
                    m_ovf_s[i] = 1'b1;
                    ss = MAXV;
                end
                m_s[i] = ss;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_inc(input int i, input int v);
        evt_inc[i*IW +: IW] = IW'(v);
    endtask

    task automatic rand_inputs();
        enable     = ($urandom_range(0, 3) != 0);
        clear      = ($urandom_range(0, 15) == 0);
        snap_valid = ($urandom_range(0, 3) == 0);
        out_ready  = $urandom_range(0, 1) != 0;
        for (int i = 0; i < N; i++) set_inc(i, $urandom_range(0, 15));
    endtask

    // Live counter / flag / handshake checker
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            chk($sformatf("ctr_wrap[%0d]", i), ctr_w[i*CW +: CW], m_w[i]);
            chk($sformatf("ctr_sat[%0d]", i), ctr_s[i*CW +: CW], m_s[i]);
            chk($sformatf("ovf_wrap[%0d]", i), ovf_w[i], exp_ovf(m_ovf_w[i]));
            chk($sformatf("ovf_sat[%0d]", i), ovf_s[i], exp_ovf(m_ovf_s[i]));
        end
        chk("snap_ready", snap_ready, !m_busy);
        chk("out_valid", out_valid, m_busy);
        chk("sat_out_valid", s_out_valid, 0);
    end

    // Stream monitor: pops on accepted beats, compares held payload while stalled
    beat_t mon_e;
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: got idx %0d data %0d expected no beat", out_idx, out_data);
            end else begin
                mon_e = sb[0];
                chk(out_ready ? "beat_idx" : "stall_idx", out_idx, mon_e.idx);
                chk(out_ready ? "beat_data" : "stall_data", out_data, mon_e.data);
                chk(out_ready ? "beat_last" : "stall_last", out_last, mon_e.last);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        // Reset
        step(); step();
        reset_n = 1'b1;
        chk("rst_snap_ready", snap_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);

        // Basic accumulate: 5 x 3 = 15 on counter 0
        enable = 1'b1;
        set_inc(0, 3);
        repeat (5) step();
        chk("acc_ctr0", ctr_w[0 +: CW], 15);
        for (int i = 1; i < N; i++) chk("acc_other", ctr_w[i*CW +: CW], 0);
        enable = 1'b0;

        // Wrap / saturate boundary at 254 + 3
        clear = 1'b1; step(); clear = 1'b0;
        enable = 1'b1; evt_inc = '0; set_inc(0, 15);
        repeat (16) step();
        set_inc(0, 14); step();
        chk("pre_wrap", ctr_w[0 +: CW], 254);
        chk("pre_sat", ctr_s[0 +: CW], 254);
        set_inc(0, 3); step();
        chk("wrap_val", ctr_w[0 +: CW], 1);
        chk("sat_val", ctr_s[0 +: CW], 255);
`ifdef PERF_CTR_OVF_EN
        chk("wrap_ovf", ovf_w[0], 1);
        chk("sat_ovf", ovf_s[0], 1);
`endif
        step();
        chk("wrap_val2", ctr_w[0 +: CW], 4);
        chk("sat_hold", ctr_s[0 +: CW], 255);

        // Clear beats increment; enable low holds
        clear = 1'b1;
        for (int i = 0; i < N; i++) set_inc(i, 7);
        step(); clear = 1'b0;
        chk("clr_ctr0", ctr_w[0 +: CW], 0);
        chk("clr_ovf0", ovf_w[0], 0);
        for (int i = 0; i < N; i++) set_inc(i, 5);
        step();
        enable = 1'b0;
        repeat (3) step();
        chk("hold_ctr0", ctr_w[0 +: CW], 5);
        chk("hold_ctr13", ctr_w[13*CW +: CW], 5);

        // Preload 10,20,...,140 then snapshot with increments still running
        clear = 1'b1; step(); clear = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < N; i++) set_inc(i, i + 1);
        repeat (10) step();
        chk("preload13", ctr_w[13*CW +: CW], 140);
        snap_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < N; i++) set_inc(i, $urandom_range(0, 15));
        step();
        snap_valid = 1'b0;
        chk("snap_first_valid", out_valid, 1);
        chk("snap_first_idx", out_idx, 0);
        chk("snap_first_data", out_data, 10);
        for (int b = 1; b < N; b++) begin
            for (int i = 0; i < N; i++) set_inc(i, $urandom_range(0, 15));
            step();
            chk("snap_data", out_data, 10 * (b + 1));
            chk("snap_last", out_last, (b == N - 1));
        end
        step();
        chk("snap_ready_back", snap_ready, 1);
        chk("snap_done_valid", out_valid, 0);

        // Random traffic with backpressure and snapshot requests during streams
        repeat (400) begin
            rand_inputs();
            step();
        end

        // Reset during beat 5
        clear = 1'b0; snap_valid = 1'b0; out_ready = 1'b1;
        repeat (20) step();
        snap_valid = 1'b1; step(); snap_valid = 1'b0;
        repeat (5) step();
        chk("pre_rst_idx", out_idx, 5);
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", snap_ready, 1);
        chk("mid_rst_ctr0", ctr_w[0 +: CW], 0);
        step(); step();
        reset_n = 1'b1;
        repeat (5) begin
            enable = 1'b1;
            for (int i = 0; i < N; i++) set_inc(i, $urandom_range(0, 15));
            step();
        end

        // Drain
        snap_valid = 1'b0; out_ready = 1'b1; clear = 1'b0;
        repeat (30) step();
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
